// File: rtl/mc_seq_pkg.sv
// Shared state, fault-code and step constants for the multi-cycle sequencer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_IMEM  = 2'd1,
        FLT_DMEM  = 2'd2,
        FLT_ALIGN = 2'd3
    } fault_code_e;

    localparam int unsigned INSTR_STEP = 4;

endpackage

// File: rtl/mc_cpu_sequencer_if.sv
// Instruction/data memory req-ack bundle between the sequencer (master) and memories (slave).
interface mc_cpu_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/mc_seq_timeout.sv
// Request watchdog: counts un-acked request cycles; MEM_TIMEOUT=0 disables expiry.
module mc_seq_timeout #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic active_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i && !ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the request cycle that would be the MEM_TIMEOUT-th without ack; a same-cycle ack wins.
    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            assign expired_o = active_i && !ack_i && (cnt_q == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/mc_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer owning PC and IR.
// Optional SEQ_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module mc_cpu_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0040_0000),
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic               clk_in,
    input  logic               reset,
    mc_cpu_sequencer_if.master mem,
    input  logic               dec_is_load,
    input  logic               dec_is_store,
    input  logic               dec_is_jump,
    input  logic               dec_is_branch,
    input  logic               dec_wb,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic [XLEN-1:0]    jump_target,
    output logic [XLEN-1:0]    pc,
    output logic [31:0]        ir,
    output logic               rf_we,
    output logic [2:0]         state,
    output logic               fault,
    output logic [1:0]         fault_code
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
`endif
);
    seq_state_e      state_q, state_d;
    fault_code_e     code_q, code_d;
    logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0]     ir_q, ir_d;
    logic            run_q;
    logic            commit;
    logic            tmo_active, tmo_ack, tmo_clear, tmo_expired;

    // run_q holds requests off until the first edge after reset release.
    assign tmo_active = run_q && ((state_q == FETCH) || (state_q == MEM));
    assign tmo_ack    = (state_q == FETCH) ? mem.imem_ack : mem.dmem_ack;
    assign tmo_clear  = (state_d != state_q);

    mc_seq_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_in),
        .rst_ni   (reset),
        .clear_i  (tmo_clear),
        .active_i (tmo_active),
        .ack_i    (tmo_ack),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        commit  = 1'b0;
        case (state_q)
            FETCH: begin
                if (run_q) begin
                    if (mem.imem_ack) begin
                        ir_d    = mem.imem_rdata;
                        state_d = DECODE;
                    end else if (tmo_expired) begin
                        code_d  = FLT_IMEM;
                        state_d = FAULT;
                    end
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (dec_is_jump) begin
                    npc_d = jump_target;
                end else if (dec_is_branch && branch_taken) begin
                    npc_d = branch_target;
                end else begin
                    npc_d = pc_q + XLEN'(INSTR_STEP);
                end
                if (npc_d[1:0] != 2'b00) begin
                    code_d  = FLT_ALIGN;
                    state_d = FAULT;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = MEM;
                end else if (dec_wb) begin
                    state_d = WB;
                end else begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (mem.dmem_ack) begin
                    if (dec_is_store) begin
                        commit  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (tmo_expired) begin
                    code_d  = FLT_DMEM;
                    state_d = FAULT;
                end
            end
            WB: begin
                commit  = 1'b1;
                state_d = FETCH;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
        if (commit) begin
            pc_d = npc_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            code_q  <= FLT_NONE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    assign mem.imem_req  = run_q && (state_q == FETCH);
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = (state_q == MEM);
    assign mem.dmem_we   = (state_q == MEM) && dec_is_store;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign rf_we         = (state_q == WB);
    assign state         = state_q;
    assign fault         = (state_q == FAULT);
    assign fault_code    = code_q;

`ifdef SEQ_PERF_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != FAULT) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (commit) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_mc_cpu_sequencer.sv
// Directed bench: a per-instruction model queues expected cycle records, compared each cycle.
module tb_mc_cpu_sequencer;
    import mc_seq_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam int unsigned TMO     = 15;
    localparam int unsigned N_FAULT = 3;

    typedef enum {K_ALU, K_NOP, K_LOAD, K_STORE, K_JUMP, K_BRANCH} kind_e;

    typedef struct {
        logic [2:0]  st;
        logic        ireq, dreq, dwe, rfwe, flt;
        logic [1:0]  code;
        logic [31:0] pc, ir;
        logic        iack, dack;
        logic [31:0] rdata;
        logic        ld, sto, jmp, br, wb, tk;
        logic [31:0] btgt, jtgt;
    } cyc_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        dec_is_load, dec_is_store, dec_is_jump, dec_is_branch, dec_wb;
    logic        branch_taken;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, ir;
    logic        rf_we, fault;
    logic [2:0]  state;
    logic [1:0]  fault_code;
`ifdef SEQ_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    mc_cpu_sequencer_if #(.XLEN(XLEN)) mif ();

    mc_cpu_sequencer #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .mem          (mif),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_is_jump  (dec_is_jump),
        .dec_is_branch(dec_is_branch),
        .dec_wb       (dec_wb),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .pc           (pc),
        .ir           (ir),
        .rf_we        (rf_we),
        .state        (state),
        .fault        (fault),
        .fault_code   (fault_code)
`ifdef SEQ_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    cyc_t        sb[$];
    cyc_t        cur;
    logic [31:0] m_pc, m_ir;
    logic [1:0]  m_code;
    int unsigned n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic ireq, input logic dreq,
                        input logic dwe, input logic rfwe, input logic iack, input logic dack);
        cyc_t r;
        r      = cur;
        r.st   = st;
        r.ireq = ireq;
        r.dreq = dreq;
        r.dwe  = dwe;
        r.rfwe = rfwe;
        r.flt  = (st == 3'd7);
        r.code = m_code;
        r.pc   = m_pc;
        r.ir   = m_ir;
        r.iack = iack;
        r.dack = dack;
        sb.push_back(r);
    endtask

    // Stray imem_ack during FAULT must be ignored and leave everything frozen.
    task automatic fault_rec(input logic [1:0] c);
        m_code = c;
        repeat (N_FAULT) push(FAULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic plan(input kind_e k, input int unsigned iwait, input int unsigned dwait,
                        input logic [31:0] rdata, input logic [31:0] tgt, input logic taken);
        logic [31:0] npc;
        cur       = '{default: '0};
        cur.rdata = rdata;
        cur.ld    = (k == K_LOAD);
        cur.sto   = (k == K_STORE);
        cur.jmp   = (k == K_JUMP);
        cur.br    = (k == K_BRANCH);
        cur.wb    = (k == K_ALU) || (k == K_LOAD);
        cur.tk    = taken;
        cur.jtgt  = (k == K_JUMP)   ? tgt : 32'hDEAD_BEE0;
        cur.btgt  = (k == K_BRANCH) ? tgt : 32'h0BAD_F00C;
        for (int unsigned w = 0; w <= iwait; w++) begin
            if (w == TMO) begin
                fault_rec(FLT_IMEM);
                return;
            end
            push(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, (w == iwait), 1'b0);
        end
        m_ir = rdata;
        push(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, (k == K_STORE), 1'b0);
        push(EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (k == K_JUMP || (k == K_BRANCH && taken)) npc = tgt;
        else npc = m_pc + 32'd4;
        if (npc[1:0] != 2'b00) begin
            fault_rec(FLT_ALIGN);
            return;
        end
        if (k == K_LOAD || k == K_STORE) begin
            for (int unsigned w = 0; w <= dwait; w++) begin
                if (w == TMO) begin
                    fault_rec(FLT_DMEM);
                    return;
                end
                push(MEM, 1'b0, 1'b1, (k == K_STORE), 1'b0, 1'b0, (w == dwait));
            end
        end
        if (k == K_LOAD || k == K_ALU) push(WB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        m_pc = npc;
    endtask

    // n == 0 drains the whole scoreboard.
    task automatic run(input int unsigned n);
        cyc_t        r;
        int unsigned cnt = 0;
        while (sb.size() > 0 && (n == 0 || cnt < n)) begin
            r = sb.pop_front();
            cnt++;
            @(negedge clk_in);
            chk("state", 32'(state), 32'(r.st));
            chk("ctrl", 32'({mif.imem_req, mif.dmem_req, mif.dmem_we, rf_we, fault, fault_code}),
                        32'({r.ireq, r.dreq, r.dwe, r.rfwe, r.flt, r.code}));
            chk("pc", pc, r.pc);
            chk("imem_addr", mif.imem_addr, r.pc);
            chk("ir", ir, r.ir);
            mif.imem_ack   = r.iack;
            mif.imem_rdata = r.iack ? r.rdata : $urandom();
            mif.dmem_ack   = r.dack;
            dec_is_load    = r.ld;
            dec_is_store   = r.sto;
            dec_is_jump    = r.jmp;
            dec_is_branch  = r.br;
            dec_wb         = r.wb;
            branch_taken   = r.tk;
            branch_target  = r.btgt;
            jump_target    = r.jtgt;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_ctrl", 32'({mif.imem_req, mif.dmem_req, mif.dmem_we, rf_we, fault, fault_code}), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, 32'd0);
        sb.delete();
        m_pc   = RST_PC;
        m_ir   = '0;
        m_code = FLT_NONE;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        mif.dmem_ack   = 1'b0;
        dec_is_load    = 1'b0;
        dec_is_store   = 1'b0;
        dec_is_jump    = 1'b0;
        dec_is_branch  = 1'b0;
        dec_wb         = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = '0;
        jump_target    = '0;
        #2;
        do_reset();

        plan(K_ALU,    0,  0, 32'h2108_0001, 32'h0,          1'b0); run(0);
        plan(K_LOAD,   0,  3, 32'h8D09_0000, 32'h0,          1'b0); run(0);
        plan(K_STORE,  0,  0, 32'hAD09_0004, 32'h0,          1'b0); run(0);
        plan(K_BRANCH, 0,  0, 32'h1109_003C, 32'h0040_0100, 1'b1); run(0);
        plan(K_BRANCH, 0,  0, 32'h1109_0040, 32'h0040_0200, 1'b0); run(0);
        plan(K_JUMP,   0,  0, 32'h0810_0000, 32'h0040_0000, 1'b0); run(0);
        plan(K_NOP,    2,  0, 32'h0000_0000, 32'h0,          1'b0); run(0);
        plan(K_ALU,   14,  0, 32'h2108_0002, 32'h0,          1'b0); run(0);
        plan(K_LOAD,   0, 14, 32'h8D0A_0008, 32'h0,          1'b0); run(0);
        plan(K_JUMP,   0,  0, 32'h0BFF_FFFF, 32'hFFFF_FFFC, 1'b0); run(0);
        plan(K_NOP,    0,  0, 32'h0000_0000, 32'h0,          1'b0); run(0);
        plan(K_NOP,  100,  0, 32'h0000_0000, 32'h0,          1'b0); run(0);

        do_reset();
        plan(K_JUMP,   0,  0, 32'h0810_0000, 32'h0040_0002, 1'b0); run(0);

        do_reset();
        plan(K_LOAD,   0, 100, 32'h8D0B_000C, 32'h0,         1'b0); run(0);

        do_reset();
        plan(K_LOAD,   0, 100, 32'h8D0C_0010, 32'h0,         1'b0); run(5);
        do_reset();
        plan(K_ALU,    0,  0, 32'h2108_0003, 32'h0,          1'b0); run(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
